m_cluster_responder: RTL
========================

M_CLUSTER_RESPONDER -- requirements
Module: m_cluster_responder

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port w_req_valid, input, 1 bit: the cluster request is present.
REQ-004 SHALL have port w_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port w_req_addr, input, 32 bits: physical byte address from the selected hart.
REQ-006 SHALL have port w_req_wdata, input, 32 bits: store data, right-aligned.
REQ-007 SHALL have port w_req_ctrl, input, 3 bits: [1:0] size (0 byte, 1 half, 2 word, 3 illegal); [2] reserved, ignored.
REQ-008 SHALL have port w_flush, input, 1 bit: invalidate the line buffer.
REQ-009 SHALL have port w_interconnect_busy, output, 1 bit: the responder cannot accept a request.
REQ-010 SHALL have port w_resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port w_resp_err, output, 1 bit: one-cycle misaligned/illegal pulse, coincident with w_resp_valid.
REQ-012 SHALL have port w_data_data, output, 128 bits: 16-byte line containing the addressed byte.
REQ-013 SHALL have port w_is_dram_data, output, 1 bit: w_data_data came from DRAM, not from the line buffer.
REQ-014 SHALL have port w_dram_req, output, 1 bit: backend request.
REQ-015 SHALL have port w_dram_we, output, 1 bit: backend write.
REQ-016 SHALL have port w_dram_addr, output, 32 bits: line address, bits [3:0] = 0.
REQ-017 SHALL have port w_dram_wdata, output, 128 bits: backend write data.
REQ-018 SHALL have port w_dram_mask, output, 16 bits: backend byte enables.
REQ-019 SHALL have port w_dram_busy, input, 1 bit: the backend stalls the request.
REQ-020 SHALL have port w_dram_rvalid, input, 1 bit: backend read data valid.
REQ-021 SHALL have port w_dram_odata, input, 128 bits: backend read data.

Function
REQ-022 SHALL implement the FSM states IDLE, RD_ISSUE, RD_WAIT and WR_ISSUE; w_interconnect_busy SHALL be 1 exactly when state != IDLE (registered, no combinational path from w_req_valid).
REQ-023 SHALL accept a request only in IDLE with w_req_valid=1; the requester holds the request until w_resp_valid.
REQ-024 SHALL hold a single-entry line buffer: valid bit, 28-bit tag (addr[31:4]) and 128-bit data.
REQ-025 Misaligned or illegal accepted requests SHALL complete in 1 cycle with w_resp_valid=w_resp_err=1, no DRAM access and no buffer change. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-026 A read hit (valid, tag match, w_flush=0) SHALL stay in IDLE and pulse w_resp_valid on the next cycle, with w_data_data = buffer data and w_is_dram_data=0; total latency 1 cycle, busy never asserted.
REQ-027 A read miss SHALL go IDLE->RD_ISSUE with w_dram_req=1, w_dram_we=0 and w_dram_addr={addr[31:4],4'b0}. RD_ISSUE->RD_WAIT SHALL occur on the cycle where w_dram_busy=0.
REQ-028 In RD_WAIT, on w_dram_rvalid: load the buffer (valid=1, tag, data), register w_data_data=w_dram_odata, set w_is_dram_data=1, pulse w_resp_valid next cycle and return to IDLE.
REQ-029 A store SHALL go IDLE->WR_ISSUE. In WR_ISSUE, w_dram_wdata SHALL hold the data replicated into every lane of its size, and w_dram_mask SHALL be 1, 3 or 15 shifted left by addr[3:0]. On w_dram_busy=0: return to IDLE and pulse w_resp_valid.
REQ-030 A store whose tag matches a valid buffer SHALL merge the masked bytes into the buffer at WR_ISSUE completion; a store miss SHALL not allocate.
REQ-031 w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata and w_dram_mask SHALL stay stable while w_dram_busy=1.
REQ-032 w_flush SHALL clear valid on the next edge in any state.
REQ-033 w_flush coincident with a hit-read acceptance SHALL turn the read into a miss.
REQ-034 w_flush during RD_WAIT SHALL still let the arriving line be loaded, with valid=1.
REQ-035 w_dram_rvalid outside RD_WAIT SHALL be ignored.
REQ-036 w_req_valid while busy SHALL be ignored; no queuing.
REQ-037 Addresses SHALL wrap at 2^32 with no carry; the tag covers the full range including 0xFFFFFFF0.

Reset
REQ-038 RST=1 SHALL immediately force the following, independent of CLK and including mid-transaction: state=IDLE; w_interconnect_busy, w_resp_valid, w_resp_err, w_is_dram_data, w_dram_req, w_dram_we = 0; w_dram_addr, w_dram_wdata, w_dram_mask, w_data_data = 0; buffer valid=0.
REQ-039 After RST deasserts, a pending backend w_dram_rvalid SHALL be ignored per REQ-035.

Verification
REQ-040 Read miss then hit: load 0x80001004, DRAM returns 128'h00112233_44556677_8899AABB_CCDDEEFF after 3 cycles -> busy for RD_ISSUE+RD_WAIT, w_is_dram_data=1; then load 0x8000100C -> same line 1 cycle later, w_is_dram_data=0, no w_dram_req.
REQ-041 Byte store hit: store byte 0xA5 to 0x80001003 -> w_dram_mask=16'h0008, w_dram_wdata lanes=0xA5; then load 0x80001000 -> buffer byte 3 = 0xA5.
REQ-042 Backend stall: w_dram_busy=1 for 5 cycles on a miss -> w_dram_req and w_dram_addr constant for 5 cycles, busy=1 throughout.
REQ-043 Misaligned: word load at 0x80000002 -> w_resp_valid=w_resp_err=1 next cycle, w_dram_req never 1.
REQ-044 Flush plus hit: w_flush with a load to the cached line -> miss path taken, w_is_dram_data=1.
REQ-045 Reset mid-read: RST pulsed in RD_WAIT -> w_dram_req=0 and busy=0 immediately; later w_dram_rvalid -> no w_resp_valid, buffer invalid.

Source files
------------

// File: rtl/m_cluster_responder.sv
// m_cluster_responder: cluster load/store responder with a single 16-byte line buffer in front of a 128-bit DRAM backend
module m_cluster_responder (
  input  logic         CLK,
  input  logic         RST,
  input  logic         w_req_valid,
  input  logic         w_req_we,
  input  logic [31:0]  w_req_addr,
  input  logic [31:0]  w_req_wdata,
  input  logic [2:0]   w_req_ctrl,
  input  logic         w_flush,
  output logic         w_interconnect_busy,
  output logic         w_resp_valid,
  output logic         w_resp_err,
  output logic [127:0] w_data_data,
  output logic         w_is_dram_data,
  output logic         w_dram_req,
  output logic         w_dram_we,
  output logic [31:0]  w_dram_addr,
  output logic [127:0] w_dram_wdata,
  output logic [15:0]  w_dram_mask,
  input  logic         w_dram_busy,
  input  logic         w_dram_rvalid,
  input  logic [127:0] w_dram_odata
);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;
  state_t state, state_nx;
  logic buf_valid;
  logic [27:0] buf_tag;
  logic [127:0] buf_data, merged, rep;
  logic [15:0] mask;
  logic [1:0] size;
  logic misal, accept, hit, wr_done, rd_done, ctrl_unused;
  assign size = w_req_ctrl[1:0];
  assign ctrl_unused = w_req_ctrl[2];
  assign misal = size == 2'd3 || (size == 2'd1 && w_req_addr[0]) || (size == 2'd2 && w_req_addr[1:0] != 2'd0);
  // the finished request is still held during its resp_valid cycle, so it must not be taken again
  assign accept = state == IDLE && w_req_valid && !w_resp_valid;
  assign hit = buf_valid && buf_tag == w_req_addr[31:4] && !w_flush;
  assign wr_done = state == WR_ISSUE && !w_dram_busy;
  assign rd_done = state == RD_WAIT && w_dram_rvalid;
  assign rep = size == 2'd0 ? {16{w_req_wdata[7:0]}} : size == 2'd1 ? {8{w_req_wdata[15:0]}} : {4{w_req_wdata}};
  assign mask = (size == 2'd0 ? 16'h0001 : size == 2'd1 ? 16'h0003 : 16'h000F) << w_req_addr[3:0];
  always_comb begin
    merged = buf_data;
    for (int i = 0; i < 16; i++) if (w_dram_mask[i]) merged[8*i +: 8] = w_dram_wdata[8*i +: 8];
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && !misal) state_nx = w_req_we ? WR_ISSUE : hit ? IDLE : RD_ISSUE;
      RD_ISSUE: if (!w_dram_busy) state_nx = RD_WAIT;
      RD_WAIT:  if (w_dram_rvalid) state_nx = IDLE;
      default:  if (!w_dram_busy) state_nx = IDLE;
    endcase
  end
  always_comb begin
    w_interconnect_busy = state != IDLE;
    w_dram_req = state == RD_ISSUE || state == WR_ISSUE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      w_resp_valid <= 1'b0;
      w_resp_err <= 1'b0;
      w_data_data <= '0;
      w_is_dram_data <= 1'b0;
      w_dram_we <= 1'b0;
      w_dram_addr <= '0;
      w_dram_wdata <= '0;
      w_dram_mask <= '0;
      buf_valid <= 1'b0;
      buf_tag <= '0;
      buf_data <= '0;
    end else begin
      w_resp_valid <= 1'b0;
      w_resp_err <= 1'b0;
      if (accept && misal) begin
        w_resp_valid <= 1'b1;
        w_resp_err <= 1'b1;
      end else if (accept && !w_req_we && hit) begin
        w_resp_valid <= 1'b1;
        w_data_data <= buf_data;
        w_is_dram_data <= 1'b0;
      end else if (accept) begin
        w_dram_addr <= {w_req_addr[31:4], 4'h0};
        w_dram_we <= w_req_we;
        w_dram_wdata <= w_req_we ? rep : '0;
        w_dram_mask <= w_req_we ? mask : '0;
      end
      // an arriving line wins over a same-cycle flush
      if (rd_done) begin
        w_resp_valid <= 1'b1;
        w_data_data <= w_dram_odata;
        w_is_dram_data <= 1'b1;
        buf_valid <= 1'b1;
        buf_tag <= w_dram_addr[31:4];
        buf_data <= w_dram_odata;
      end else if (w_flush) buf_valid <= 1'b0;
      if (wr_done) begin
        w_resp_valid <= 1'b1;
        if (buf_valid && buf_tag == w_dram_addr[31:4]) buf_data <= merged;
      end
    end
endmodule
